lw_sha_msg_schedule: RTL and testbench
======================================

LW_SHA_MSG_SCHEDULE -- requirements
Module: lw_sha_msg_schedule

Interface
REQ-001: Parameters: none; word width SHALL be `WORD_SIZE (32 under CORE_ARCH_S32, 64 under CORE_ARCH_S64) from defines.v.
REQ-002: clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003: rst_ni  input  1  reset, synchronous, active-low.
REQ-004: mode_i  input  1  present only under CORE_ARCH_S64; 0 = SHA-256, 1 = SHA-512.
REQ-005: block_valid_i  input  1  message block offered.
REQ-006: block_ready_o  output  1  block can be accepted.
REQ-007: block_i  input  16*`WORD_SIZE  padded block; W[0] in most-significant word.
REQ-008: round_valid_o  output  1  word_o/round_index_o valid for the round stage.
REQ-009: round_ready_i  input  1  round stage consumes current word.
REQ-010: word_o  output  `WORD_SIZE  schedule word W[t], plain (unmasked) form.
REQ-011: round_index_o  output  7  t, drives the round stage's round_index.
REQ-012: last_round_o  output  1  t equals final round index.

Function
REQ-013: FSM SHALL have exactly two states: IDLE and RUN.
REQ-014: In IDLE, block_ready_o = 1 and round_valid_o = 0; in RUN, block_ready_o = 0 and round_valid_o = 1.
REQ-015: Block acceptance (block_valid_i & block_ready_o) SHALL load block_i into a 16-word buffer buf[0..15] (buf[0] = W[0]), clear the round counter, latch mode_i, and enter RUN.
REQ-016: The first word SHALL be valid on the cycle after acceptance (latency 1).
REQ-017: word_o SHALL equal buf[0]; round_index_o SHALL equal the round counter.
REQ-018: On accept (round_valid_o & round_ready_i) not in the last round: buf[i] <= buf[i+1] for i = 0..14; buf[15] <= s1(buf[14]) + buf[9] + s0(buf[1]) + buf[0] mod 2^`WORD_SIZE; counter increments.
REQ-019: SHA-256: s0 = ror7^ror18^shr3, s1 = ror17^ror19^shr10. SHA-512: s0 = ror1^ror8^shr7, s1 = ror19^ror61^shr6.
REQ-020: Final index SHALL be 63 (SHA-256) or 79 (SHA-512); last_round_o = round_valid_o & (counter == final).
REQ-021: Accept in the final round SHALL zeroize buf and counter and return to IDLE; a new block can be accepted the following cycle.
REQ-022: With round_ready_i = 0, buf, counter, word_o and round_index_o SHALL hold unchanged for any number of cycles.
REQ-023: block_valid_i and mode_i SHALL be ignored in RUN; latched mode SHALL not change mid-block.
REQ-024: Under CORE_ARCH_S32, SHA-256 behaviour is fixed and no mode register exists.

Reset
REQ-025: rst_ni = 0 on a clock edge SHALL force IDLE, zero buf, counter and latched mode, regardless of the current state, including mid-block.
REQ-026: Outputs after reset: block_ready_o = 1, round_valid_o = 0, word_o = 0, round_index_o = 0, last_round_o = 0.
REQ-027: A block aborted by reset SHALL produce no further round_valid_o.

Structure
REQ-028: small_sigma0/small_sigma1 functions (mode-selectable under S64) and the round-count constants (64, 80) SHALL reside in lw_sha_pkg, alongside right_rotate.
REQ-029: The block SHALL have no sub-modules; it is a single module with a buffer, counter and FSM.

Verification
REQ-030: SHA-256 "abc" block (0x61626380, 14x0, 0x00000018), round_ready_i = 1 -> W[0] = 0x61626380 at t = 0, W[16] = 0x61626380, W[17] = 0x000F0000, 64 words, last_round_o only at t = 63, then block_ready_o = 1.
REQ-031: Same block with round_ready_i toggling 1/0 -> identical word sequence; word_o and round_index_o stable during every stalled cycle.
REQ-032: rst_ni low at t = 20 -> next cycle IDLE, round_valid_o = 0, word_o = 0; the next block restarts at t = 0.
REQ-033: Two blocks offered back-to-back -> second accepted the cycle after the first block's t = 63 accept; no gap or duplicate word.
REQ-034: S64, mode_i = 1, "abc" SHA-512 block -> 80 words matching the reference model; last_round_o at t = 79; toggling mode_i mid-block has no effect.
REQ-035: All-zero block -> every W[t] = 0 for all rounds; buf is zero after completion.

Source files
------------

// File: rtl/lw_sha_pkg.sv
// Shared types, round-count constants and sigma helpers for the SHA-2 message schedule.
// Word width follows the core architecture macro; SHA-512 support exists only on 64-bit cores.
`ifndef WORD_SIZE
`ifdef CORE_ARCH_S64
`define WORD_SIZE 64
`else
`define WORD_SIZE 32
`endif
`endif

package lw_sha_pkg;

   localparam int unsigned WORD_W     = `WORD_SIZE;
   localparam int unsigned ROUNDS_256 = 64;
   localparam int unsigned ROUNDS_512 = 80;
   localparam logic [6:0]  LAST_IDX_256 = 7'(ROUNDS_256 - 1);
   localparam logic [6:0]  LAST_IDX_512 = 7'(ROUNDS_512 - 1);

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

`ifdef CORE_ARCH_S64
   function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // Narrow (SHA-256) operation works on the low 32 bits and returns them zero-extended.
   function automatic word_t right_rotate(input word_t x, input int unsigned n, input logic wide);
      if (wide) return ror64(x, n);
      return {32'b0, ror32(x[31:0], n)};
   endfunction

   function automatic word_t small_sigma0(input word_t x, input logic wide);
      if (wide) return right_rotate(x, 1, 1'b1) ^ right_rotate(x, 8, 1'b1) ^ (x >> 7);
      return right_rotate(x, 7, 1'b0) ^ right_rotate(x, 18, 1'b0) ^ {32'b0, x[31:0] >> 3};
   endfunction

   function automatic word_t small_sigma1(input word_t x, input logic wide);
      if (wide) return right_rotate(x, 19, 1'b1) ^ right_rotate(x, 61, 1'b1) ^ (x >> 6);
      return right_rotate(x, 17, 1'b0) ^ right_rotate(x, 19, 1'b0) ^ {32'b0, x[31:0] >> 10};
   endfunction
`else
   function automatic word_t right_rotate(input word_t x, input int unsigned n);
      return ror32(x, n);
   endfunction

   function automatic word_t small_sigma0(input word_t x);
      return right_rotate(x, 7) ^ right_rotate(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t small_sigma1(input word_t x);
      return right_rotate(x, 17) ^ right_rotate(x, 19) ^ (x >> 10);
   endfunction
`endif

endpackage

// File: rtl/lw_sha_msg_schedule.sv
// SHA-2 message schedule: 16-word sliding buffer emitting W[t] to the round stage, one word per accept.
// State table:  ST_IDLE | waiting for a block, buffer zero   ST_RUN | presenting W[t] to the round stage
`ifndef WORD_SIZE
`ifdef CORE_ARCH_S64
`define WORD_SIZE 64
`else
`define WORD_SIZE 32
`endif
`endif

module lw_sha_msg_schedule
   import lw_sha_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       rst_ni,
`ifdef CORE_ARCH_S64
   input  logic                       mode_i,
`endif
   input  logic                       block_valid_i,
   output logic                       block_ready_o,
   input  logic [16*`WORD_SIZE-1:0]   block_i,
   output logic                       round_valid_o,
   input  logic                       round_ready_i,
   output logic [`WORD_SIZE-1:0]      word_o,
   output logic [6:0]                 round_index_o,
   output logic                       last_round_o
);

   state_e     state_q, state_d;
   word_t      msg_buf_q [16];
   word_t      msg_buf_d [16];
   logic [6:0] cnt_q, cnt_d;
   logic [6:0] last_idx;
   word_t      new_w;

`ifdef CORE_ARCH_S64
   logic mode_q, mode_d;

   assign last_idx = mode_q ? LAST_IDX_512 : LAST_IDX_256;
`else
   assign last_idx = LAST_IDX_256;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      msg_buf_d = msg_buf_q;
`ifdef CORE_ARCH_S64
      mode_d    = mode_q;
      new_w     = small_sigma1(msg_buf_q[14], mode_q) + msg_buf_q[9]
                + small_sigma0(msg_buf_q[1], mode_q) + msg_buf_q[0];
      // SHA-256 words stay 32-bit on a 64-bit core; drop carries out of bit 31.
      if (!mode_q) new_w[63:32] = '0;
`else
      new_w     = small_sigma1(msg_buf_q[14]) + msg_buf_q[9]
                + small_sigma0(msg_buf_q[1]) + msg_buf_q[0];
`endif

      case (state_q)
         ST_IDLE: begin
            if (block_valid_i) begin
               for (int i = 0; i < 16; i++) begin
                  msg_buf_d[i] = block_i[(15-i)*WORD_W +: WORD_W];
               end
               cnt_d   = '0;
`ifdef CORE_ARCH_S64
               mode_d  = mode_i;
`endif
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (round_ready_i) begin
               if (cnt_q == last_idx) begin
                  for (int i = 0; i < 16; i++) begin
                     msg_buf_d[i] = '0;
                  end
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  for (int i = 0; i < 15; i++) begin
                     msg_buf_d[i] = msg_buf_q[i+1];
                  end
                  msg_buf_d[15] = new_w;
                  cnt_d         = cnt_q + 7'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         for (int i = 0; i < 16; i++) begin
            msg_buf_q[i] <= '0;
         end
`ifdef CORE_ARCH_S64
         mode_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         msg_buf_q <= msg_buf_d;
`ifdef CORE_ARCH_S64
         mode_q    <= mode_d;
`endif
      end
   end

   assign block_ready_o = (state_q == ST_IDLE);
   assign round_valid_o = (state_q == ST_RUN);
   assign word_o        = msg_buf_q[0];
   assign round_index_o = cnt_q;
   assign last_round_o  = round_valid_o & (cnt_q == last_idx);

endmodule

// File: tb/tb_lw_sha_msg_schedule.sv
// Scoreboard bench for lw_sha_msg_schedule: reference schedule words queued at block accept, popped per round accept.
`ifndef WORD_SIZE
`ifndef CORE_ARCH_S32
`ifndef CORE_ARCH_S64
`define CORE_ARCH_S64
`endif
`endif
`ifdef CORE_ARCH_S64
`define WORD_SIZE 64
`else
`define WORD_SIZE 32
`endif
`endif

module tb_lw_sha_msg_schedule;

   localparam int W = `WORD_SIZE;

   typedef struct {
      logic [W-1:0] w;
      logic [6:0]   idx;
      logic         last;
   } exp_t;

   logic                 clk_i = 1'b0;
   logic                 rst_ni = 1'b0;
   logic                 mode_i = 1'b0;
   logic                 block_valid_i = 1'b0;
   logic                 block_ready_o;
   logic [16*W-1:0]      block_i = '0;
   logic                 round_valid_o;
   logic                 round_ready_i = 1'b0;
   logic [W-1:0]         word_o;
   logic [6:0]           round_index_o;
   logic                 last_round_o;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];

   always #5 clk_i = ~clk_i;

   lw_sha_msg_schedule dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
`ifdef CORE_ARCH_S64
      .mode_i        (mode_i),
`endif
      .block_valid_i (block_valid_i),
      .block_ready_o (block_ready_o),
      .block_i       (block_i),
      .round_valid_o (round_valid_o),
      .round_ready_i (round_ready_i),
      .word_o        (word_o),
      .round_index_o (round_index_o),
      .last_round_o  (last_round_o)
   );

   function automatic logic [31:0] m_rotr32(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   function automatic logic [63:0] m_rotr64(input logic [63:0] x, input int n);
      logic [127:0] d;
      d = {x, x} >> n;
      return d[63:0];
   endfunction

   // kind 0: "abc" padded block, kind 1: all-zero block
   task automatic make_block(input int kind, input logic m, output logic [W-1:0] blk [16]);
      for (int i = 0; i < 16; i++) blk[i] = '0;
      if (kind == 0) begin
         if (m) blk[0] = W'(64'h6162_6380_0000_0000);
         else   blk[0] = W'(32'h6162_6380);
         blk[15] = W'(8'h18);
      end
   endtask

   task automatic model_schedule(input logic [W-1:0] blk [16], input logic m,
                                 output logic [W-1:0] ws [80]);
      logic [31:0] a32 [64];
      logic [63:0] a64 [80];
      for (int t = 0; t < 80; t++) ws[t] = '0;
      if (m) begin
         for (int t = 0; t < 16; t++) a64[t] = 64'(blk[t]);
         for (int t = 16; t < 80; t++) begin
            a64[t] = (m_rotr64(a64[t-2], 19) ^ m_rotr64(a64[t-2], 61) ^ (a64[t-2] >> 6))
                   + a64[t-7]
                   + (m_rotr64(a64[t-15], 1) ^ m_rotr64(a64[t-15], 8) ^ (a64[t-15] >> 7))
                   + a64[t-16];
         end
         for (int t = 0; t < 80; t++) ws[t] = W'(a64[t]);
      end else begin
         for (int t = 0; t < 16; t++) a32[t] = blk[t][31:0];
         for (int t = 16; t < 64; t++) begin
            a32[t] = (m_rotr32(a32[t-2], 17) ^ m_rotr32(a32[t-2], 19) ^ (a32[t-2] >> 10))
                   + a32[t-7]
                   + (m_rotr32(a32[t-15], 7) ^ m_rotr32(a32[t-15], 18) ^ (a32[t-15] >> 3))
                   + a32[t-16];
         end
         for (int t = 0; t < 64; t++) ws[t] = W'(a32[t]);
      end
   endtask

   task automatic test_reset();
      rst_ni        = 1'b0;
      block_valid_i = 1'b0;
      round_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      n_checks += 5;
      if (block_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset block_ready_o: got %b expected 1", block_ready_o); end
      if (round_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset round_valid_o: got %b expected 0", round_valid_o); end
      if (word_o !== '0) begin n_errors++; $display("FAIL reset word_o: got %h expected 0", word_o); end
      if (round_index_o !== 7'd0) begin n_errors++; $display("FAIL reset round_index_o: got %0d expected 0", round_index_o); end
      if (last_round_o !== 1'b0) begin n_errors++; $display("FAIL reset last_round_o: got %b expected 0", last_round_o); end
      rst_ni = 1'b1;
   endtask

   // Generic scenario driver: offers nblk copies of a block, optional stalls, optional reset at round abort_at.
   task automatic run_case(input string name, input int kind, input logic m, input int nblk,
                           input bit stall, input int abort_at, input bit b2b_check, input bit lit_check);
      logic [W-1:0] blk [16];
      logic [W-1:0] ws [80];
      logic [W-1:0] prev_w;
      logic [6:0]   prev_i;
      int  accepted  = 0;
      int  cyc       = 0;
      int  last_pop  = -100;
      int  nr;
      bit  done      = 0;
      bit  aborted   = 0;
      bit  prev_stall = 0;
      bit  reset_now = 0;
      exp_t e;

      nr = m ? 80 : 64;
      make_block(kind, m, blk);
      model_schedule(blk, m, ws);
      for (int i = 0; i < 16; i++) block_i[(15-i)*W +: W] = blk[i];
      exp_q.delete();
      prev_w = '0;
      prev_i = '0;

      while (!done && cyc < 600) begin
         @(negedge clk_i);
         cyc++;
         if (reset_now) begin
            reset_now = 0;
            rst_ni    = 1'b1;
            n_checks += 3;
            if (round_valid_o !== 1'b0) begin n_errors++; $display("FAIL %s abort round_valid_o: got %b expected 0", name, round_valid_o); end
            if (word_o !== '0) begin n_errors++; $display("FAIL %s abort word_o: got %h expected 0", name, word_o); end
            if (block_ready_o !== 1'b1) begin n_errors++; $display("FAIL %s abort block_ready_o: got %b expected 1", name, block_ready_o); end
         end

         n_checks++;
         if (block_ready_o !== !round_valid_o) begin
            n_errors++;
            $display("FAIL %s handshake: block_ready_o %b with round_valid_o %b", name, block_ready_o, round_valid_o);
         end

         if (round_valid_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL %s unexpected word: got t=%0d %h expected no round_valid_o", name, round_index_o, word_o);
            end else begin
               e = exp_q[0];
               if (word_o !== e.w || round_index_o !== e.idx || last_round_o !== e.last) begin
                  n_errors++;
                  $display("FAIL %s word: got t=%0d w=%h last=%b expected t=%0d w=%h last=%b",
                           name, round_index_o, word_o, last_round_o, e.idx, e.w, e.last);
               end
            end
            if (prev_stall) begin
               n_checks++;
               if (word_o !== prev_w || round_index_o !== prev_i) begin
                  n_errors++;
                  $display("FAIL %s stall hold: got t=%0d w=%h expected t=%0d w=%h",
                           name, round_index_o, word_o, prev_i, prev_w);
               end
            end
            if (b2b_check && round_index_o == 7'd0 && last_pop > 0) begin
               n_checks++;
               if (cyc - last_pop != 2) begin
                  n_errors++;
                  $display("FAIL %s back-to-back gap: got %0d cycles expected 2", name, cyc - last_pop);
               end
               last_pop = -100;
            end
            if (lit_check && round_index_o == 7'd16) begin
               n_checks++;
               if (word_o !== W'(32'h6162_6380)) begin n_errors++; $display("FAIL %s W16: got %h expected 61626380", name, word_o); end
            end
            if (lit_check && round_index_o == 7'd17) begin
               n_checks++;
               if (word_o !== W'(32'h000F_0000)) begin n_errors++; $display("FAIL %s W17: got %h expected 000f0000", name, word_o); end
            end
         end

         if (abort_at >= 0 && !aborted && round_valid_o && round_index_o == 7'(abort_at)) begin
            rst_ni        = 1'b0;
            reset_now     = 1;
            aborted       = 1;
            block_valid_i = 1'b0;
            round_ready_i = 1'b1;
            prev_stall    = 0;
            exp_q.delete();
            continue;
         end

         round_ready_i = stall ? ((cyc % 2) == 1) : 1'b1;
         prev_stall    = round_valid_o && !round_ready_i;
         prev_w        = word_o;
         prev_i        = round_index_o;
         if (round_valid_o && round_ready_i && exp_q.size() > 0) begin
            if (exp_q[0].last) last_pop = cyc;
            void'(exp_q.pop_front());
         end

         block_valid_i = (accepted < nblk);
         if (block_valid_i && block_ready_o) begin
            mode_i = m;
            for (int t = 0; t < nr; t++) begin
               e.w    = ws[t];
               e.idx  = 7'(t);
               e.last = (t == nr - 1);
               exp_q.push_back(e);
            end
            accepted++;
         end else begin
            // Latched mode must ignore the live input while a block runs.
            mode_i = ~mode_i;
            if (accepted == nblk && exp_q.size() == 0 && block_ready_o) begin
               done = 1;
               n_checks += 2;
               if (word_o !== '0) begin n_errors++; $display("FAIL %s zeroize word_o: got %h expected 0", name, word_o); end
               if (round_index_o !== 7'd0) begin n_errors++; $display("FAIL %s zeroize round_index_o: got %0d expected 0", name, round_index_o); end
            end
         end
      end

      block_valid_i = 1'b0;
      round_ready_i = 1'b0;
      if (!done) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s timeout: got %0d words pending expected 0 within 600 cycles", name, exp_q.size());
      end
   endtask

   task automatic test_abc256();
      run_case("abc256", 0, 1'b0, 1, 1'b0, -1, 1'b0, 1'b1);
   endtask

   task automatic test_stall();
      run_case("stall", 0, 1'b0, 1, 1'b1, -1, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      run_case("reset_mid", 0, 1'b0, 2, 1'b0, 20, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_case("back_to_back", 0, 1'b0, 2, 1'b0, -1, 1'b1, 1'b1);
   endtask

   task automatic test_sha512();
`ifdef CORE_ARCH_S64
      run_case("abc512", 0, 1'b1, 1, 1'b0, -1, 1'b0, 1'b0);
      run_case("abc512_stall", 0, 1'b1, 1, 1'b1, -1, 1'b0, 1'b0);
`endif
   endtask

   task automatic test_zero();
      run_case("zero256", 1, 1'b0, 1, 1'b0, -1, 1'b0, 1'b0);
`ifdef CORE_ARCH_S64
      run_case("zero512", 1, 1'b1, 1, 1'b0, -1, 1'b0, 1'b0);
`endif
   endtask

   initial begin
      test_reset();
      test_abc256();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_sha512();
      test_zero();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
